pipelined_cla_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/pipelined_cla_adder.sv | 116 +++++++++++
 tb/tb_pipelined_cla_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit CLA slice per stage,
// slice carry registered between stages, valid/ready flow control with global stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int STAGES = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_block
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
    end

    // Flat lookahead: each carry is an OR of generate terms propagated through
    // the intervening bits, so no carry depends on a lower carry within the slice.
    function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             c0);
        logic [BLOCK-1:0] p, g;
        logic [BLOCK:0]   c;
        logic             term;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = c0;
            for (int k = 0; k <= i; k++) c[i+1] = c[i+1] & p[k];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic             vld_p [STAGES];
    logic [WIDTH-1:0] res_p [STAGES];
    logic [WIDTH-1:0] opa_p [STAGES];
    logic [WIDTH-1:0] opb_p [STAGES];
    logic             cry_p [STAGES];

    logic [WIDTH-1:0] stg_a [STAGES];
    logic [WIDTH-1:0] stg_b [STAGES];
    logic [WIDTH-1:0] stg_r [STAGES];
    logic             stg_c [STAGES];
    logic [WIDTH-1:0] nxt_r [STAGES];
    logic             nxt_c [STAGES];
    logic [BLOCK:0]   sl    [STAGES];
    logic             advance;

    always_comb begin
        stg_a[0] = a;
        stg_b[0] = b ^ {WIDTH{sub}};
        stg_c[0] = cin ^ sub;
        stg_r[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_a[k] = opa_p[k-1];
            stg_b[k] = opb_p[k-1];
            stg_c[k] = cry_p[k-1];
            stg_r[k] = res_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sl[k]    = cla_slice(stg_a[k][k*BLOCK +: BLOCK], stg_b[k][k*BLOCK +: BLOCK], stg_c[k]);
            nxt_r[k] = stg_r[k];
            nxt_r[k][k*BLOCK +: BLOCK] = sl[k][BLOCK-1:0];
            nxt_c[k] = sl[k][BLOCK];
        end
    end

    // Stage registers: the whole pipe shifts together or holds together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                res_p[k] <= '0;
                opa_p[k] <= '0;
                opb_p[k] <= '0;
                cry_p[k] <= 1'b0;
            end
        end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
            for (int k = 0; k < STAGES; k++) begin
                res_p[k] <= nxt_r[k];
                cry_p[k] <= nxt_c[k];
                opa_p[k] <= stg_a[k];
                opb_p[k] <= stg_b[k];
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign result    = res_p[STAGES-1];
    assign cout      = cry_p[STAGES-1];
    // Same-sign operands whose sum flips sign; sign bits ride along in the last stage.
    assign overflow  = (opa_p[STAGES-1][WIDTH-1] ~^ opb_p[STAGES-1][WIDTH-1])
                     & (res_p[STAGES-1][WIDTH-1] ^ opa_p[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed corner cases plus random
// streams with random flow control on three width/slice configurations.
module tb_pipelined_cla_adder;

    logic clk;
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar ci = 0; ci < 3; ci++) begin : g_cfg
        localparam int W  = (ci == 1) ? 16 : 32;
        localparam int BL = (ci == 0) ? 8 : ((ci == 1) ? 4 : 32);
        localparam int ST = W / BL;

        logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
        logic [W-1:0] a, b, result;
        logic [W+1:0] q[$];
        int           got = 0;
        bit           done = 0;

        pipelined_cla_adder #(.WIDTH(W), .BLOCK(BL)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready),
            .result(result), .cout(cout), .overflow(overflow)
        );

        // Reference: integer arithmetic on the effective operands; overflow from signed range.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input logic s);
            logic [W-1:0] yb;
            longint       us, ss, lim, c0;
            yb  = s ? ~y : y;
            c0  = (c ^ s) ? 1 : 0;
            us  = longint'({32'd0, x}) + longint'({32'd0, yb}) + c0;
            ss  = longint'($signed(x)) + longint'($signed(yb)) + c0;
            lim = longint'(1) << (W - 1);
            return {us[W-1:0], us[W], (ss >= lim) || (ss < -lim)};
        endfunction

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(W-1){1'b0}}};
                3:       return {1'b0, {(W-1){1'b1}}};
                default: return W'($urandom);
            endcase
        endfunction

        always @(negedge clk) begin
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg%0d unexpected_out actual=0x%0h expected=no output", ci, result);
                end else begin
                    logic [W+1:0] e;
                    e = q.pop_front();
                    chk(result == e[W+1:2], $sformatf("cfg%0d result", ci), longint'(result), longint'(e[W+1:2]));
                    chk(cout == e[1], $sformatf("cfg%0d cout", ci), longint'(cout), longint'(e[1]));
                    chk(overflow == e[0], $sformatf("cfg%0d overflow", ci), longint'(overflow), longint'(e[0]));
                    got++;
                end
            end
        end

        task automatic reset_seq();
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            @(negedge clk);
            chk(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
            chk(result == '0, "rst_result", longint'(result), 0);
            chk(cout == 1'b0, "rst_cout", longint'(cout), 0);
            chk(overflow == 1'b0, "rst_overflow", longint'(overflow), 0);
            chk(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
            @(posedge clk);
            #1;
            rst = 1'b0; out_ready = 1'b1;
        endtask

        task automatic drain();
            int i;
            out_ready = 1'b1; in_valid = 1'b0;
            i = 0;
            while (q.size() != 0 && i < 200) begin
                @(posedge clk);
                i++;
            end
            #1;
            chk(q.size() == 0, $sformatf("cfg%0d drain", ci), longint'(q.size()), 0);
        endtask

        // Single op with a fixed expectation; also measures cycles until out_valid.
        task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                input logic s, input logic [W+1:0] exp, input string nm);
            int n;
            out_ready = 1'b1; in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
            @(negedge clk);
            chk(in_ready == 1'b1, {nm, "_in_ready"}, longint'(in_ready), 1);
            q.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            chk(n == ST, {nm, "_latency"}, longint'(n), longint'(ST));
            drain();
        endtask

        task automatic rand_ops(input int n);
            int sent, cyc;
            sent = 0; cyc = 0;
            while (sent < n && cyc < 60000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 3) != 0);
                a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    q.push_back(model(a, b, cin, sub));
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            chk(sent == n, $sformatf("cfg%0d random_sent", ci), longint'(sent), longint'(n));
        endtask

        if (ci == 0) begin : g_dir
            initial begin
                logic [W-1:0] frz;
                int issued, stall, base, n;
                bit stalled;
                reset_seq();
                send_exp(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1}, "t1");
                send_exp(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0}, "t2");
                send_exp(32'h5, 32'h7, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0}, "t3a");
                send_exp(32'h80000000, 32'h1, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1}, "t3b");

                // Back-to-back stream with a 3-cycle downstream stall after the 2nd result.
                base = got; issued = 0; stall = 0; stalled = 0; frz = '0;
                for (int cyc = 0; cyc < 100 && got < base + 8; cyc++) begin
                    if (!stalled && got - base >= 2) begin stall = 3; stalled = 1; end
                    out_ready = (stall == 0);
                    in_valid  = (issued < 8);
                    a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
                    @(negedge clk);
                    if (stall > 0) begin
                        chk(in_ready == 1'b0, "t4_in_ready_stall", longint'(in_ready), 0);
                        chk(out_valid == 1'b1, "t4_out_valid_stall", longint'(out_valid), 1);
                        if (stall == 3) frz = result;
                        else chk(result == frz, "t4_frozen", longint'(result), longint'(frz));
                        stall--;
                    end
                    if (in_valid && in_ready) begin
                        q.push_back(model(a, b, cin, sub));
                        issued++;
                    end
                    @(posedge clk);
                    #1;
                end
                chk(got == base + 8, "t4_results", longint'(got - base), 8);
                chk(stalled == 1'b1, "t4_stall_seen", longint'(stalled), 1);
                drain();

                // Reset with three ops in flight; none of them may emerge.
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
                    @(negedge clk);
                    if (in_ready) q.push_back(model(a, b, cin, sub));
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                chk(in_ready == 1'b1, "t5_in_ready_rst", longint'(in_ready), 1);
                @(posedge clk);
                #1;
                @(negedge clk);
                chk(out_valid == 1'b0, "t5_out_valid", longint'(out_valid), 0);
                chk(result == '0, "t5_result", longint'(result), 0);
                chk(cout == 1'b0, "t5_cout", longint'(cout), 0);
                chk(overflow == 1'b0, "t5_overflow", longint'(overflow), 0);
                q.delete();
                rst = 1'b0;
                repeat (8) @(posedge clk);
                #1;
                n = got;
                send_exp(32'h12345678, 32'h11111111, 1'b1, 1'b0, {32'h23456789 + 32'h1, 1'b0, 1'b0}, "t5_after");
                chk(got == n + 1, "t5_after_count", longint'(got - n), 1);

                rand_ops(10000);
                drain();
                done = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                reset_seq();
                rand_ops(10000);
                drain();
                done = 1'b1;
            end
        end
    end

    initial begin
        wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "simulation time limit");
    end

endmodule
